ervp_axi_burst_initiator: RTL and testbench



---
 rtl/ervp_axi_burst_initiator.sv | 185 ++++++++++++++++++
 tb/tb_ervp_axi_burst_initiator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ervp_axi_burst_initiator.sv
// rtl/ervp_axi_burst_initiator.sv - single-outstanding AXI INCR burst initiator
// Turns a command plus write/read streams into AXI bursts; one transaction in flight at a time.
module ervp_axi_burst_initiator #(
  parameter int BW_ADDR    = 32,
  parameter int BW_DATA    = 32,
  parameter int BW_AXI_TID = 4,
  parameter int TID_VALUE  = 0
) (
  input  logic                    clk,
  input  logic                    rstnn,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [BW_ADDR-1:0]      cmd_addr,
  input  logic [7:0]              cmd_len,

  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BW_DATA-1:0]      wr_data,
  input  logic [BW_DATA/8-1:0]    wr_strb,

  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [BW_DATA-1:0]      rd_data,
  output logic                    rd_last,

  output logic                    done,
  output logic                    done_error,

  output logic [BW_AXI_TID-1:0]   sxawid,
  output logic [BW_ADDR-1:0]      sxawaddr,
  output logic [7:0]              sxawlen,
  output logic [2:0]              sxawsize,
  output logic [1:0]              sxawburst,
  output logic                    sxawvalid,
  input  logic                    sxawready,

  output logic [BW_AXI_TID-1:0]   sxwid,
  output logic [BW_DATA-1:0]      sxwdata,
  output logic [BW_DATA/8-1:0]    sxwstrb,
  output logic                    sxwlast,
  output logic                    sxwvalid,
  input  logic                    sxwready,

  input  logic [BW_AXI_TID-1:0]   sxbid,
  input  logic [1:0]              sxbresp,
  input  logic                    sxbvalid,
  output logic                    sxbready,

  output logic [BW_AXI_TID-1:0]   sxarid,
  output logic [BW_ADDR-1:0]      sxaraddr,
  output logic [7:0]              sxarlen,
  output logic [2:0]              sxarsize,
  output logic [1:0]              sxarburst,
  output logic                    sxarvalid,
  input  logic                    sxarready,

  input  logic [BW_AXI_TID-1:0]   sxrid,
  input  logic [BW_DATA-1:0]      sxrdata,
  input  logic [1:0]              sxrresp,
  input  logic                    sxrlast,
  input  logic                    sxrvalid,
  output logic                    sxrready
);

  localparam logic [2:0]         AXSIZE   = 3'($clog2(BW_DATA/8));
  localparam logic [BW_ADDR-1:0] LSB_MASK = BW_ADDR'(BW_DATA/8 - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t               state, state_next;
  logic [BW_ADDR-1:0]   addr_q;
  logic [7:0]           len_q;
  logic [7:0]           beat_cnt;
  logic                 err_q;
  logic                 done_q;
  logic                 done_err_q;

  logic cmd_hs, w_hs, w_last, b_hs, r_hs, r_last_hs;

  assign cmd_hs    = (state == S_IDLE) && cmd_valid;
  assign w_last    = (beat_cnt == len_q);
  assign w_hs      = (state == S_W) && wr_valid && sxwready;
  assign b_hs      = (state == S_B) && sxbvalid;
  assign r_hs      = (state == S_R) && sxrvalid && rd_ready;
  assign r_last_hs = r_hs && sxrlast;

  // IDs are single-valued, so returned IDs carry no information
  logic unused_ids;
  assign unused_ids = ^{sxbid, sxrid};

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (cmd_valid) state_next = cmd_write ? S_AW : S_AR;
      S_AW:   if (sxawready) state_next = S_W;
      S_W:    if (w_hs && w_last) state_next = S_B;
      S_B:    if (sxbvalid) state_next = S_IDLE;
      S_AR:   if (sxarready) state_next = S_R;
      S_R:    if (r_last_hs) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt   <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      if (cmd_hs) begin
        addr_q   <= cmd_addr & ~LSB_MASK;
        len_q    <= cmd_len;
        beat_cnt <= '0;
        err_q    <= 1'b0;
      end else begin
        if (w_hs) beat_cnt <= beat_cnt + 8'd1;
        if ((b_hs && sxbresp != 2'b00) || (r_hs && sxrresp != 2'b00)) err_q <= 1'b1;
      end
      // the final response beat is folded in directly so its status is not lost
      done_q     <= b_hs || r_last_hs;
      done_err_q <= (b_hs && (err_q || sxbresp != 2'b00)) ||
                    (r_last_hs && (err_q || sxrresp != 2'b00));
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    sxawvalid = 1'b0;
    sxwvalid  = 1'b0;
    wr_ready  = 1'b0;
    sxbready  = 1'b0;
    sxarvalid = 1'b0;
    sxrready  = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_AW:   sxawvalid = 1'b1;
      S_W: begin
        sxwvalid = wr_valid;
        wr_ready = sxwready;
      end
      S_B:    sxbready  = 1'b1;
      S_AR:   sxarvalid = 1'b1;
      S_R: begin
        sxrready = rd_ready;
        rd_valid = sxrvalid;
        rd_last  = sxrlast;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign sxawid    = BW_AXI_TID'(TID_VALUE);
  assign sxawaddr  = addr_q;
  assign sxawlen   = len_q;
  assign sxawsize  = AXSIZE;
  assign sxawburst = 2'b01;

  assign sxwid     = BW_AXI_TID'(TID_VALUE);
  assign sxwdata   = wr_data;
  assign sxwstrb   = wr_strb;
  assign sxwlast   = w_last;

  assign sxarid    = BW_AXI_TID'(TID_VALUE);
  assign sxaraddr  = addr_q;
  assign sxarlen   = len_q;
  assign sxarsize  = AXSIZE;
  assign sxarburst = 2'b01;

  assign rd_data    = sxrdata;
  assign done       = done_q;
  assign done_error = done_err_q;

endmodule

// File: tb/tb_ervp_axi_burst_initiator.sv
// tb/tb_ervp_axi_burst_initiator.sv - scoreboard bench for ervp_axi_burst_initiator
// Stimulus pushes expectations; a negedge monitor pops and compares on every handshake.
module tb_ervp_axi_burst_initiator;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done, done_error;
  logic [3:0]  sxawid, sxwid, sxbid, sxarid, sxrid;
  logic [31:0] sxawaddr, sxaraddr, sxwdata, sxrdata;
  logic [7:0]  sxawlen, sxarlen;
  logic [2:0]  sxawsize, sxarsize;
  logic [1:0]  sxawburst, sxarburst, sxbresp, sxrresp;
  logic [3:0]  sxwstrb;
  logic        sxawvalid, sxawready, sxwlast, sxwvalid, sxwready;
  logic        sxbvalid, sxbready, sxarvalid, sxarready;
  logic        sxrlast, sxrvalid, sxrready;

  ervp_axi_burst_initiator dut (
    .clk(clk), .rstnn(rstnn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_error(done_error),
    .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
    .sxawburst(sxawburst), .sxawvalid(sxawvalid), .sxawready(sxawready),
    .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast),
    .sxwvalid(sxwvalid), .sxwready(sxwready),
    .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
    .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
    .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
    .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
    .sxrvalid(sxrvalid), .sxrready(sxrready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  logic [31:0] exp_aw_addr[$], exp_ar_addr[$], exp_w_data[$], exp_rd_data[$];
  logic [7:0]  exp_aw_len[$], exp_ar_len[$];
  logic        exp_w_last[$], exp_rd_last[$], exp_done[$];

  // slave model configuration and state
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] mem[int];
  int          aw_wait, w_idx, r_idx;
  logic [31:0] w_addr, r_addr;
  logic [7:0]  r_len;
  logic        b_pend, r_act;

  function automatic logic [31:0] rd_word(input int idx);
    if (mem.exists(idx)) return mem[idx];
    return {16'hD00D, 16'(idx * 4)};
  endfunction

  initial begin
    aw_wait = 0; w_idx = 0; r_idx = 0; b_pend = 0; r_act = 0;
    w_addr = 0; r_addr = 0; r_len = 0;
    sxawready = 1'b1; sxwready = 1'b1; sxarready = 1'b1;
    sxbvalid = 1'b0; sxbresp = 2'b00; sxbid = 4'd0;
    sxrvalid = 1'b0; sxrdata = '0; sxrresp = 2'b00; sxrlast = 1'b0; sxrid = 4'd0;
    forever begin
      @(negedge clk);
      if (!rstnn) begin
        aw_wait = 0; b_pend = 0; r_act = 0; r_idx = 0;
      end else begin
        if (sxawvalid && sxawready) begin
          aw_wait = 0; w_addr = sxawaddr; w_idx = 0;
        end else if (sxawvalid) aw_wait++;
        if (sxwvalid && sxwready) begin
          mem[int'(w_addr >> 2) + w_idx] = sxwdata;
          w_idx++;
          if (sxwlast) b_pend = 1;
        end
        if (sxbvalid && sxbready) b_pend = 0;
        if (sxarvalid && sxarready) begin
          r_addr = sxaraddr; r_len = sxarlen; r_idx = 0; r_act = 1;
        end else if (sxrvalid && sxrready) begin
          if (r_idx == int'(r_len)) r_act = 0;
          else r_idx++;
        end
      end
      @(posedge clk); #1;
      sxawready = (aw_wait >= aw_delay);
      sxbvalid  = b_pend;
      sxbresp   = bresp_cfg;
      sxrvalid  = r_act;
      sxrdata   = rd_word(int'(r_addr >> 2) + r_idx);
      sxrlast   = (r_idx == int'(r_len));
    end
  end

  // monitor / scoreboard
  int   cmd_cyc = 0, aw_cyc = 0, end_cyc = 0, stall_cnt = 0;
  logic w_first = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rstnn) begin
        if (cmd_valid && cmd_ready) cmd_cyc = cyc;
        if (sxawvalid && !sxawready && exp_aw_addr.size() > 0) begin
          chk("aw_stall_addr", sxawaddr, exp_aw_addr[0]);
          chk("aw_stall_len", sxawlen, exp_aw_len[0]);
          chk("w_before_aw", sxwvalid, 1'b0);
          stall_cnt++;
        end
        if (sxawvalid && sxawready) begin
          if (exp_aw_addr.size() == 0) fail_now("aw_unexpected");
          else begin
            chk("aw_addr", sxawaddr, exp_aw_addr.pop_front());
            chk("aw_len", sxawlen, exp_aw_len.pop_front());
            chk("aw_size", sxawsize, 3'd2);
            chk("aw_burst", sxawburst, 2'b01);
            chk("aw_id", sxawid, 4'd0);
            chk("aw_latency", cyc - cmd_cyc, 1 + aw_delay);
          end
          aw_cyc = cyc;
          w_first = 1;
        end
        if (sxwvalid && sxwready) begin
          if (exp_w_data.size() == 0) fail_now("w_unexpected");
          else begin
            chk("w_data", sxwdata, exp_w_data.pop_front());
            chk("w_last", sxwlast, exp_w_last.pop_front());
            chk("w_strb", sxwstrb, 4'hF);
          end
          if (w_first) chk("w_first_latency", cyc, aw_cyc + 1);
          w_first = 0;
        end
        if (sxarvalid && sxarready) begin
          if (exp_ar_addr.size() == 0) fail_now("ar_unexpected");
          else begin
            chk("ar_addr", sxaraddr, exp_ar_addr.pop_front());
            chk("ar_len", sxarlen, exp_ar_len.pop_front());
            chk("ar_size", sxarsize, 3'd2);
            chk("ar_burst", sxarburst, 2'b01);
            chk("ar_latency", cyc - cmd_cyc, 1);
          end
        end
        if (rd_valid) chk("rready_mirror", sxrready, rd_ready);
        if (rd_valid && rd_ready) begin
          if (exp_rd_data.size() == 0) fail_now("rd_unexpected");
          else begin
            chk("rd_data", rd_data, exp_rd_data.pop_front());
            chk("rd_last", rd_last, exp_rd_last.pop_front());
          end
        end
        if (sxbvalid && sxbready) end_cyc = cyc;
        if (sxrvalid && sxrready && sxrlast) end_cyc = cyc;
        if (done) begin
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else begin
            chk("done_error", done_error, exp_done.pop_front());
            chk("done_latency", cyc, end_cyc + 1);
          end
        end
        if (done_error && !done) fail_now("done_error_without_done");
      end
    end
  end

  // stimulus
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) fail_now("cmd_timeout");
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic send_beats(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      wr_valid = 1; wr_data = base + 32'(i); wr_strb = 4'hF;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (wr_valid && wr_ready) begin ok = 1; break; end
      end
      if (!ok) fail_now("w_timeout");
      @(posedge clk); #1;
    end
    wr_valid = 0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) return;
    end
    fail_now("done_timeout");
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base,
                          input logic err);
    exp_aw_addr.push_back(addr & 32'hFFFF_FFFC);
    exp_aw_len.push_back(len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_w_data.push_back(base + 32'(i));
      exp_w_last.push_back(i == int'(len));
    end
    exp_done.push_back(err);
    send_cmd(1'b1, addr, len);
    send_beats(base, int'(len) + 1);
    wait_done();
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d[$],
                         input bit toggle);
    bit seen = 0;
    exp_ar_addr.push_back(addr & 32'hFFFF_FFFC);
    exp_ar_len.push_back(len);
    for (int i = 0; i <= int'(len); i++) begin
      exp_rd_data.push_back(d[i]);
      exp_rd_last.push_back(i == int'(len));
    end
    exp_done.push_back(1'b0);
    rd_ready = 1;
    send_cmd(1'b0, addr, len);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
      if (toggle) rd_ready = ~rd_ready;
    end
    if (!seen) fail_now("read_done_timeout");
    rd_ready = 1;
  endtask

  initial begin
    logic [31:0] dq[$];
    rstnn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awvalid", sxawvalid, 1'b0);
    chk("rst_wvalid", sxwvalid, 1'b0);
    chk("rst_arvalid", sxarvalid, 1'b0);
    chk("rst_bready", sxbready, 1'b0);
    chk("rst_rready", sxrready, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_done", {done, done_error}, 2'b00);
    @(posedge clk); #1;
    rstnn = 1;

    do_write(32'h100, 8'd3, 32'hA0, 1'b0);
    dq = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_read(32'h100, 8'd3, dq, 1'b1);

    aw_delay = 5; stall_cnt = 0;
    do_write(32'h400, 8'd1, 32'h11, 1'b0);
    chk("aw_stall_cycles", stall_cnt, 5);
    aw_delay = 0;

    bresp_cfg = 2'b10;
    do_write(32'h300, 8'd0, 32'hE0, 1'b1);
    bresp_cfg = 2'b00;
    dq = '{32'hE0};
    do_read(32'h300, 8'd0, dq, 1'b0);

    dq = '{32'hD00D_1000};
    do_read(32'h1003, 8'd0, dq, 1'b0);

    // abort a write after two of eight beats
    exp_aw_addr.push_back(32'h500); exp_aw_len.push_back(8'd7);
    exp_w_data.push_back(32'hB0); exp_w_last.push_back(1'b0);
    exp_w_data.push_back(32'hB1); exp_w_last.push_back(1'b0);
    send_cmd(1'b1, 32'h500, 8'd7);
    send_beats(32'hB0, 2);
    wr_valid = 1; wr_data = 32'hB2; wr_strb = 4'hF;
    #2 rstnn = 0;
    #1;
    chk("arst_valids", {sxawvalid, sxwvalid, sxarvalid, sxbready, sxrready, wr_ready, rd_valid, done},
        8'h00);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    wr_valid = 0;
    repeat (2) @(posedge clk);
    #1 rstnn = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);

    do_write(32'h200, 8'd1, 32'hC0, 1'b0);
    dq = '{32'hC0, 32'hC1};
    do_read(32'h200, 8'd1, dq, 1'b0);

    repeat (3) @(posedge clk);
    chk("queues_drained", exp_aw_addr.size() + exp_w_data.size() + exp_ar_addr.size() +
        exp_rd_data.size() + exp_done.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
